// File: rtl/adiv5_pkg.sv
// adiv5_pkg: shared ADIv5 SWD definitions.
//   swd_state_e  - transfer sequencer states used by swd_xfer
//   ACK_*        - 3-bit ACK encodings, bit 0 is the first bit on the wire
//   swd_req_byte - builds the 8-bit request packet, bit 0 sent first
package adiv5_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_TRN1,
    ST_ACK,
    ST_TRN2,
    ST_WDATA,
    ST_RDATA,
    ST_TRN3,
    ST_IDLE_BITS,
    ST_DONE
  } swd_state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  // start, APnDP, RnW, A2, A3, even parity, stop, park
  function automatic logic [7:0] swd_req_byte(input logic apndp, input logic rnw,
                                              input logic [1:0] addr);
    return {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

endpackage

// File: rtl/swd_clkgen.sv
// swd_clkgen: SWDCLK divider. While EN is high a tick occurs every DIV+1
// CLK cycles and SWDCLK toggles on each tick; while EN is low SWDCLK is
// held low and the divider is cleared.
//   CLK, RESET  - system clock, synchronous active-high reset
//   EN          - run the divider
//   DIV         - half-period minus 1, in CLK cycles
//   SWDCLK      - divided clock (registered)
//   RISE / FALL - high in the CLK cycle whose closing edge raises / lowers SWDCLK
module swd_clkgen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  output logic             SWDCLK,
  output logic             RISE,
  output logic             FALL
);

  logic [DIV_W-1:0] cnt_q;
  logic             clk_q;
  logic             tick;

  assign tick   = EN && (cnt_q == DIV);
  assign RISE   = tick && !clk_q;
  assign FALL   = tick && clk_q;
  assign SWDCLK = clk_q;

  always_ff @(posedge CLK) begin
    if (RESET || !EN) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      clk_q <= ~clk_q;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/swd_xfer.sv
// swd_xfer: single SWD transfer engine (request, turnaround, ACK, data,
// idle bits) with a valid/ready command port and a one-cycle response pulse.
//   CLK, RESET            - system clock, synchronous active-high reset
//   CMD_*                 - command handshake and request fields (A[3:2], write data)
//   RSP_*                 - response: ACK, read data, read parity error, retries used
//   CFG_DIV/TURN/RETRY    - divider, turnaround bits minus 1, max WAIT retries
//   SWDCLK/SWDIN/SWDOUT/SWDOE - SWD pins (SWDOE=1 means host drives)
// Build option: define SWD_WAIT_RETRY_EN to retry WAIT responses automatically.
module swd_xfer
  import adiv5_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned RETRY_W  = 4,
  parameter int unsigned IDLE_CYC = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_APNDP,
  input  logic               CMD_RNW,
  input  logic [1:0]         CMD_ADDR,
  input  logic [31:0]        CMD_WDATA,
  output logic               RSP_VALID,
  output logic [2:0]         RSP_ACK,
  output logic [31:0]        RSP_RDATA,
  output logic               RSP_PERR,
  output logic [RETRY_W-1:0] RSP_RETRIES,
  input  logic [DIV_W-1:0]   CFG_DIV,
  input  logic [1:0]         CFG_TURN,
  input  logic [RETRY_W-1:0] CFG_RETRY,
  output logic               SWDCLK,
  input  logic               SWDIN,
  output logic               SWDOUT,
  output logic               SWDOE
);

  localparam logic [5:0] IDLE_LAST = (IDLE_CYC > 0) ? 6'(IDLE_CYC - 1) : '0;

  swd_state_e       state_q, state_d, fin_state, post_state;
  logic [5:0]       bit_q;
  logic [7:0]       req_q;
  logic             rnw_q;
  logic [31:0]      wdata_q, rdata_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       turn_q;
  logic [2:0]       ack_q, ack_new;
  logic             perr_q, out_q, oe_q;
  logic             rsp_valid_q, rsp_perr_q;
  logic [2:0]       rsp_ack_q;
  logic [31:0]      rsp_rdata_q;
  logic             busy, rise, fall, turn_end, retry_ok;

  swd_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .CLK    (CLK),
    .RESET  (RESET),
    .EN     (busy),
    .DIV    (div_q),
    .SWDCLK (SWDCLK),
    .RISE   (rise),
    .FALL   (fall)
  );

`ifdef SWD_WAIT_RETRY_EN
  logic [RETRY_W-1:0] retries_q, cfg_retry_q, rsp_retries_q;
  assign RSP_RETRIES = rsp_retries_q;
`else
  logic [RETRY_W-1:0] unused_cfg_retry;
  assign unused_cfg_retry = CFG_RETRY;
  assign RSP_RETRIES      = '0;
`endif

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign CMD_READY = (state_q == ST_IDLE);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ACK   = rsp_ack_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_PERR  = rsp_perr_q;
  assign SWDOUT    = out_q;
  assign SWDOE     = oe_q;

  // Next state evaluated at each SWDCLK rising edge (one bit completed).
  always_comb begin
    retry_ok = 1'b0;
`ifdef SWD_WAIT_RETRY_EN
    retry_ok = (ack_q == ACK_WAIT) && (retries_q < cfg_retry_q);
`endif
    fin_state  = retry_ok ? ST_REQ : ST_DONE;
    post_state = (IDLE_CYC != 0) ? ST_IDLE_BITS : fin_state;
    ack_new    = {SWDIN, ack_q[1:0]};
    turn_end   = (bit_q == {4'd0, turn_q});
    state_d    = state_q;
    case (state_q)
      ST_REQ:       if (bit_q == 6'd7) state_d = ST_TRN1;
      ST_TRN1:      if (turn_end) state_d = ST_ACK;
      ST_ACK:       if (bit_q == 6'd2)
                      state_d = (ack_new == ACK_OK && rnw_q) ? ST_RDATA : ST_TRN2;
      ST_TRN2:      if (turn_end) state_d = (ack_q == ACK_OK) ? ST_WDATA : post_state;
      ST_WDATA:     if (bit_q == 6'd32) state_d = post_state;
      ST_RDATA:     if (bit_q == 6'd32) state_d = ST_TRN3;
      ST_TRN3:      if (turn_end) state_d = post_state;
      ST_IDLE_BITS: if (bit_q == IDLE_LAST) state_d = fin_state;
      default:      state_d = state_q;
    endcase
  end

  // Bits advance and SWDIN is sampled on RISE; pins change only on FALL, so
  // the first request bit is placed on the pin at command accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      req_q       <= '0;
      rnw_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      div_q       <= '0;
      turn_q      <= '0;
      ack_q       <= '0;
      perr_q      <= 1'b0;
      out_q       <= 1'b1;
      oe_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
`ifdef SWD_WAIT_RETRY_EN
      retries_q     <= '0;
      cfg_retry_q   <= '0;
      rsp_retries_q <= '0;
`endif
    end else if (state_q == ST_IDLE) begin
      if (CMD_VALID) begin
        state_q <= ST_REQ;
        bit_q   <= '0;
        req_q   <= swd_req_byte(CMD_APNDP, CMD_RNW, CMD_ADDR);
        rnw_q   <= CMD_RNW;
        wdata_q <= CMD_WDATA;
        rdata_q <= '0;
        div_q   <= CFG_DIV;
        turn_q  <= CFG_TURN;
        ack_q   <= '0;
        perr_q  <= 1'b0;
        out_q   <= 1'b1;
        oe_q    <= 1'b1;
`ifdef SWD_WAIT_RETRY_EN
        retries_q   <= '0;
        cfg_retry_q <= CFG_RETRY;
`endif
      end
    end else if (state_q == ST_DONE) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      out_q       <= 1'b1;
      oe_q        <= 1'b1;
    end else begin
      if (rise) begin
        state_q <= state_d;
        bit_q   <= (state_d != state_q) ? '0 : bit_q + 6'd1;
        if (state_q == ST_ACK) ack_q[bit_q[1:0]] <= SWDIN;
        if (state_q == ST_RDATA) begin
          if (bit_q == 6'd32) perr_q <= SWDIN ^ (^rdata_q);
          else                rdata_q <= {SWDIN, rdata_q[31:1]};
        end
        if (state_d == ST_DONE) begin
          rsp_valid_q <= 1'b1;
          rsp_ack_q   <= ack_q;
          rsp_rdata_q <= (ack_q == ACK_OK && rnw_q) ? rdata_q : '0;
          rsp_perr_q  <= (ack_q == ACK_OK && rnw_q) ? perr_q : 1'b0;
`ifdef SWD_WAIT_RETRY_EN
          rsp_retries_q <= retries_q;
`endif
        end
`ifdef SWD_WAIT_RETRY_EN
        if (state_d == ST_REQ && state_q != ST_REQ) retries_q <= retries_q + RETRY_W'(1);
`endif
      end
      if (fall) begin
        case (state_q)
          ST_REQ: begin
            out_q <= req_q[bit_q[2:0]];
            oe_q  <= 1'b1;
          end
          ST_WDATA: begin
            out_q <= (bit_q == 6'd32) ? ^wdata_q : wdata_q[bit_q[4:0]];
            oe_q  <= 1'b1;
          end
          ST_IDLE_BITS: begin
            out_q <= 1'b0;
            oe_q  <= 1'b1;
          end
          default: begin
            out_q <= 1'b1;
            oe_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swd_xfer.sv
// tb_swd_xfer: directed bench for swd_xfer with a bit-level SWD target model
// and a monitor that logs the host pin state at every SWDCLK rising edge.
module tb_swd_xfer;
  import adiv5_pkg::*;

  localparam int unsigned IDLE = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0, CMD_READY;
  logic        CMD_APNDP = 1'b0, CMD_RNW = 1'b0;
  logic [1:0]  CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID, RSP_PERR;
  logic [2:0]  RSP_ACK;
  logic [31:0] RSP_RDATA;
  logic [3:0]  RSP_RETRIES;
  logic [7:0]  CFG_DIV = '0;
  logic [1:0]  CFG_TURN = '0;
  logic [3:0]  CFG_RETRY = '0;
  logic        SWDCLK, SWDOUT, SWDOE;
  logic        SWDIN = 1'b1;

  swd_xfer #(.DIV_W(8), .RETRY_W(4), .IDLE_CYC(IDLE)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_APNDP(CMD_APNDP), .CMD_RNW(CMD_RNW), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_ACK(RSP_ACK), .RSP_RDATA(RSP_RDATA),
    .RSP_PERR(RSP_PERR), .RSP_RETRIES(RSP_RETRIES),
    .CFG_DIV(CFG_DIV), .CFG_TURN(CFG_TURN), .CFG_RETRY(CFG_RETRY),
    .SWDCLK(SWDCLK), .SWDIN(SWDIN), .SWDOUT(SWDOUT), .SWDOE(SWDOE)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Target model configuration
  logic [2:0]  s_ack [8];
  logic [31:0] s_rdata = '0;
  logic        s_corrupt = 1'b0;
  logic        s_rnw = 1'b0;
  int          s_turn = 1;
  int          pos = 0, att = 0;

  // Monitor state
  logic        q_oe [$];
  logic        q_out [$];
  int          q_cyc [$];
  int          cyc = 0, vcount = 0;
  logic        prev_clk = 1'b0;
  logic [2:0]  cap_ack = '0;
  logic [31:0] cap_rdata = '0;
  logic        cap_perr = 1'b0;
  logic [3:0]  cap_retries = '0;

  function automatic logic sbit(input int a, input int p);
    int d;
    d = p - (8 + s_turn);
    if (d < 0) return 1'b1;
    if (d < 3) return s_ack[a][d];
    if (s_ack[a] == ACK_OK && s_rnw) begin
      d = d - 3;
      if (d < 32) return s_rdata[d];
      if (d == 32) return (^s_rdata) ^ s_corrupt;
    end
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (SWDCLK && !prev_clk) begin
        q_oe.push_back(SWDOE);
        q_out.push_back(SWDOUT);
        q_cyc.push_back(cyc);
        pos++;
        if (s_ack[att] != ACK_OK && pos == 11 + 2 * s_turn + int'(IDLE)) begin
          pos = 0;
          if (att < 7) att++;
        end
        SWDIN = sbit(att, pos);
      end
      prev_clk = SWDCLK;
      if (RSP_VALID) begin
        vcount++;
        cap_ack     = RSP_ACK;
        cap_rdata   = RSP_RDATA;
        cap_perr    = RSP_PERR;
        cap_retries = RSP_RETRIES;
      end
    end
  end

  function automatic logic [63:0] grab(input bit sel_oe, input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (from + i < q_out.size()) v[i] = sel_oe ? q_oe[from + i] : q_out[from + i];
      else v[i] = 1'bx;
    end
    return v;
  endfunction

  function automatic int rise_gap();
    if (q_cyc.size() < 2) return -1;
    return q_cyc[1] - q_cyc[0];
  endfunction

  task automatic set_acks(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] rest);
    s_ack[0] = a0;
    s_ack[1] = a1;
    for (int i = 2; i < 8; i++) s_ack[i] = rest;
  endtask

  task automatic start_cmd(input logic apndp, input logic rnw, input logic [1:0] addr,
                           input logic [31:0] wd, input logic [7:0] div,
                           input logic [1:0] turn, input logic [3:0] retry);
    q_oe.delete();
    q_out.delete();
    q_cyc.delete();
    pos = 0;
    att = 0;
    vcount = 0;
    s_turn = int'(turn) + 1;
    s_rnw = rnw;
    SWDIN = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_APNDP = apndp;
    CMD_RNW   = rnw;
    CMD_ADDR  = addr;
    CMD_WDATA = wd;
    CFG_DIV   = div;
    CFG_TURN  = turn;
    CFG_RETRY = retry;
    @(negedge CLK);
    // Scramble config and command fields: they must be ignored mid-transfer.
    CMD_VALID = 1'b0;
    CMD_WDATA = 32'hFFFF_FFFF;
    CFG_DIV   = 8'hFF;
    CFG_TURN  = 2'd3;
    CFG_RETRY = 4'd0;
  endtask

  task automatic wait_rsp(input int budget);
    for (int i = 0; i < budget && vcount == 0; i++) @(negedge CLK);
    repeat (6) @(negedge CLK);
  endtask

`ifdef SWD_WAIT_RETRY_EN
  localparam logic [2:0] E1_ACK = 3'b001;
  localparam int         E1_RET = 2, E1_RISES = 78, E2_RET = 3, E2_RISES = 60;
  localparam logic [31:0] E1_DATA = 32'h2BA0_1477;
`else
  localparam logic [2:0] E1_ACK = 3'b010;
  localparam int         E1_RET = 0, E1_RISES = 15, E2_RET = 0, E2_RISES = 15;
  localparam logic [31:0] E1_DATA = 32'h0;
`endif

  initial begin
    set_acks(ACK_OK, ACK_OK, ACK_OK);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_pins", {SWDCLK, SWDOUT, SWDOE, CMD_READY}, 4'b0111);
    check("rst_valid", RSP_VALID, 1'b0);
    check("rst_ack", RSP_ACK, 3'b000);
    check("rst_rdata", RSP_RDATA, 32'h0);
    check("rst_perr", RSP_PERR, 1'b0);
    check("rst_retries", RSP_RETRIES, 4'h0);

    // A: DP read IDCODE, DIV=0, TURN=0
    s_rdata = 32'h2BA0_1477; s_corrupt = 1'b0;
    start_cmd(1'b0, 1'b1, 2'd0, 32'h0, 8'd0, 2'd0, 4'd0);
    check("A_ready_busy", CMD_READY, 1'b0);
    wait_rsp(2000);
    check("A_nrsp", vcount, 1);
    check("A_req", grab(0, 0, 8), 8'hA5);
    check("A_req_oe", grab(1, 0, 8), 8'hFF);
    check("A_trn_ack_oe", grab(1, 8, 4), 4'h0);
    check("A_rd_oe", grab(1, 12, 34), 64'h0);
    check("A_idle_out", grab(0, 46, 2), 2'b00);
    check("A_idle_oe", grab(1, 46, 2), 2'b11);
    check("A_period", rise_gap(), 2);
    check("A_nrise", q_out.size(), 48);
    check("A_ack", cap_ack, 3'b001);
    check("A_rdata", cap_rdata, 32'h2BA0_1477);
    check("A_perr", cap_perr, 1'b0);
    check("A_pins", {SWDCLK, SWDOUT, SWDOE, CMD_READY}, 4'b0111);

    // B: AP write addr 1, DIV=3
    start_cmd(1'b1, 1'b0, 2'd1, 32'h2300_0052, 8'd3, 2'd0, 4'd0);
    wait_rsp(4000);
    check("B_nrsp", vcount, 1);
    check("B_req", grab(0, 0, 8), 8'h8B);
    check("B_period", rise_gap(), 8);
    check("B_wdata", grab(0, 13, 33), 64'h0_2300_0052);
    check("B_wdata_oe", grab(1, 13, 33), 64'h1_FFFF_FFFF);
    check("B_trn2_oe", grab(1, 12, 1), 1'b0);
    check("B_nrise", q_out.size(), 48);
    check("B_ack", cap_ack, 3'b001);
    check("B_rdata", cap_rdata, 32'h0);

    // C: DP read addr 1 with corrupted parity, DIV=1, TURN=1
    s_rdata = 32'h1234_5678; s_corrupt = 1'b1;
    start_cmd(1'b0, 1'b1, 2'd1, 32'h0, 8'd1, 2'd1, 4'd0);
    wait_rsp(3000);
    check("C_nrsp", vcount, 1);
    check("C_req", grab(0, 0, 8), 8'h8D);
    check("C_trn_oe", grab(1, 8, 2), 2'b00);
    check("C_period", rise_gap(), 4);
    check("C_nrise", q_out.size(), 50);
    check("C_ack", cap_ack, 3'b001);
    check("C_rdata", cap_rdata, 32'h1234_5678);
    check("C_perr", cap_perr, 1'b1);
    s_corrupt = 1'b0;

    // D: FAULT on AP write addr 2, TURN=2
    set_acks(ACK_FAULT, ACK_FAULT, ACK_FAULT);
    start_cmd(1'b1, 1'b0, 2'd2, 32'hDEAD_BEEF, 8'd0, 2'd2, 4'd0);
    wait_rsp(2000);
    check("D_nrsp", vcount, 1);
    check("D_req", grab(0, 0, 8), 8'h93);
    check("D_trn2_oe", grab(1, 14, 3), 3'b000);
    check("D_idle_oe", grab(1, 17, 2), 2'b11);
    check("D_idle_out", grab(0, 17, 2), 2'b00);
    check("D_nrise", q_out.size(), 19);
    check("D_ack", cap_ack, 3'b100);
    check("D_rdata", cap_rdata, 32'h0);

    // E1: WAIT, WAIT, then OK on DP read IDCODE with CFG_RETRY=3
    set_acks(ACK_WAIT, ACK_WAIT, ACK_OK);
    s_rdata = 32'h2BA0_1477;
    start_cmd(1'b0, 1'b1, 2'd0, 32'h0, 8'd0, 2'd0, 4'd3);
    wait_rsp(3000);
    check("E1_nrsp", vcount, 1);
    check("E1_ack", cap_ack, E1_ACK);
    check("E1_retries", cap_retries, E1_RET);
    check("E1_rdata", cap_rdata, E1_DATA);
    check("E1_nrise", q_out.size(), E1_RISES);
`ifdef SWD_WAIT_RETRY_EN
    check("E1_req2", grab(0, 15, 8), 8'hA5);
`endif

    // E2: WAIT every time
    set_acks(ACK_WAIT, ACK_WAIT, ACK_WAIT);
    start_cmd(1'b0, 1'b1, 2'd0, 32'h0, 8'd0, 2'd0, 4'd3);
    wait_rsp(3000);
    check("E2_nrsp", vcount, 1);
    check("E2_ack", cap_ack, 3'b010);
    check("E2_retries", cap_retries, E2_RET);
    check("E2_nrise", q_out.size(), E2_RISES);

    // F: reset during RDATA bit 10, then a normal read
    set_acks(ACK_OK, ACK_OK, ACK_OK);
    start_cmd(1'b0, 1'b1, 2'd0, 32'h0, 8'd0, 2'd0, 4'd0);
    for (int i = 0; i < 500 && q_out.size() < 22; i++) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("F_pins", {SWDCLK, SWDOUT, SWDOE}, 3'b011);
    check("F_valid", RSP_VALID, 1'b0);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    check("F_nrsp", vcount, 0);
    check("F_ack_cleared", RSP_ACK, 3'b000);
    check("F_idle", {SWDCLK, SWDOUT, SWDOE, CMD_READY}, 4'b0111);
    start_cmd(1'b0, 1'b1, 2'd0, 32'h0, 8'd0, 2'd0, 4'd0);
    wait_rsp(2000);
    check("F2_nrsp", vcount, 1);
    check("F2_ack", cap_ack, 3'b001);
    check("F2_rdata", cap_rdata, 32'h2BA0_1477);
    check("F2_nrise", q_out.size(), 48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
